// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cache main-memory arbiter; optional ARB_ROUND_ROBIN_EN selects round-robin tie-break
module cache_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IReq,
  input  logic [DATA_WIDTH-1:0] IAddr,
  input  logic                  DReq,
  input  logic                  DWB,
  input  logic [DATA_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0] DVictimAddr,
  input  logic [DATA_WIDTH-1:0] DVictimData,
  input  logic [DATA_WIDTH-1:0] MemRD,
  input  logic                  MemReady,
  output logic                  IDone,
  output logic [DATA_WIDTH-1:0] IRD,
  output logic                  DDone,
  output logic [DATA_WIDTH-1:0] DRD,
  output logic                  MemEn,
  output logic                  MemWE,
  output logic [DATA_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0] MemWD,
  output logic                  IStall,
  output logic                  DStall,
  output logic                  Busy,
  output logic                  MemErr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_FILL = 3'd1,
    D_WB   = 3'd2,
    D_FILL = 3'd3,
    I_RESP = 3'd4,
    D_RESP = 3'd5
  } state_t;

  localparam logic [DATA_WIDTH-1:0] WORD_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] i_addr_q, i_addr_d;
  logic [DATA_WIDTH-1:0] d_addr_q, d_addr_d;
  logic [DATA_WIDTH-1:0] vic_addr_q, vic_addr_d;
  logic [DATA_WIDTH-1:0] vic_data_q, vic_data_d;
  logic [DATA_WIDTH-1:0] ird_q, ird_d;
  logic [DATA_WIDTH-1:0] drd_q, drd_d;
  logic                  idone_q, idone_d;
  logic                  ddone_q, ddone_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  mem_err_q, mem_err_d;
  logic                  grant_d, grant_i;
  logic                  timed_out;
  logic                  in_mem_q, in_mem_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;  // 1: D was the port served last

  // Ties go to the port not served last; the record updates on every grant
  always_comb begin
    grant_d  = DReq && (!IReq || !last_d_q);
    grant_i  = IReq && !grant_d;
    last_d_d = last_d_q;
    if (state_q == IDLE && grant_d) begin
      last_d_d = 1'b1;
    end else if (state_q == IDLE && grant_i) begin
      last_d_d = 1'b0;
    end
  end

  // Last-grant register, resets to D so the first tie goes to I
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_d_q <= 1'b1;
    else        last_d_q <= last_d_d;
  end
`else
  // Fixed priority: D wins every tie
  always_comb begin
    grant_d = DReq;
    grant_i = IReq && !DReq;
  end
`endif

  // Next state, phase counter, request latches and refill data capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_addr_d   = i_addr_q;
    d_addr_d   = d_addr_q;
    vic_addr_d = vic_addr_q;
    vic_data_d = vic_data_q;
    ird_d      = ird_q;
    drd_d      = drd_q;
    mem_err_d  = mem_err_q;
    timed_out  = !MemReady && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_d) begin
          d_addr_d   = DAddr & WORD_MASK;
          vic_addr_d = DVictimAddr & WORD_MASK;
          vic_data_d = DVictimData;
          state_d    = DWB ? D_WB : D_FILL;
        end else if (grant_i) begin
          i_addr_d = IAddr & WORD_MASK;
          state_d  = I_FILL;
        end
      end
      D_WB: begin
        if (MemReady) begin
          state_d = D_FILL;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d   = D_RESP;
          drd_d     = MemRD;
          mem_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      D_FILL: begin
        if (MemReady || timed_out) begin
          state_d = D_RESP;
          drd_d   = MemRD;
          cnt_d   = '0;
          if (!MemReady) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      I_FILL: begin
        if (MemReady || timed_out) begin
          state_d = I_RESP;
          ird_d   = MemRD;
          cnt_d   = '0;
          if (!MemReady) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      I_RESP, D_RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered memory-port and Done outputs; memory outputs lag the state by one cycle
  always_comb begin
    in_mem_q = (state_q == I_FILL) || (state_q == D_WB) || (state_q == D_FILL);
    in_mem_d = (state_d == I_FILL) || (state_d == D_WB) || (state_d == D_FILL);
    idone_d  = (state_d == I_RESP);
    ddone_d  = (state_d == D_RESP);
    mem_en_d = in_mem_q && in_mem_d;
    mem_we_d = mem_en_d && (state_q == D_WB);
    mem_a_d  = '0;
    if (mem_en_d) begin
      case (state_q)
        D_WB:    mem_a_d = vic_addr_q;
        D_FILL:  mem_a_d = d_addr_q;
        I_FILL:  mem_a_d = i_addr_q;
        default: mem_a_d = '0;
      endcase
    end
    mem_wd_d = mem_we_d ? vic_data_q : '0;
  end

  // State and datapath registers, cleared asynchronously so a reset aborts silently
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      i_addr_q   <= '0;
      d_addr_q   <= '0;
      vic_addr_q <= '0;
      vic_data_q <= '0;
      ird_q      <= '0;
      drd_q      <= '0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_addr_q   <= i_addr_d;
      d_addr_q   <= d_addr_d;
      vic_addr_q <= vic_addr_d;
      vic_data_q <= vic_data_d;
      ird_q      <= ird_d;
      drd_q      <= drd_d;
      idone_q    <= idone_d;
      ddone_q    <= ddone_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign IDone  = idone_q;
  assign DDone  = ddone_q;
  assign IRD    = ird_q;
  assign DRD    = drd_q;
  assign MemEn  = mem_en_q;
  assign MemWE  = mem_we_q;
  assign MemA   = mem_a_q;
  assign MemWD  = mem_wd_q;
  assign MemErr = mem_err_q;
  assign Busy   = (state_q != IDLE);
  assign IStall = IReq & ~idone_q;
  assign DStall = DReq & ~ddone_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IReq, DReq, DWB, MemReady;
  logic [31:0] IAddr, DAddr, DVictimAddr, DVictimData, MemRD;
  logic        IDone, DDone, MemEn, MemWE, IStall, DStall, Busy, MemErr;
  logic [31:0] IRD, DRD, MemA, MemWD;

  cache_mem_arbiter #(.DATA_WIDTH(32), .MEM_TIMEOUT(15), .CNT_WIDTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWB(DWB), .DAddr(DAddr), .DVictimAddr(DVictimAddr), .DVictimData(DVictimData),
    .MemRD(MemRD), .MemReady(MemReady),
    .IDone(IDone), .IRD(IRD), .DDone(DDone), .DRD(DRD),
    .MemEn(MemEn), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD),
    .IStall(IStall), .DStall(DStall), .Busy(Busy), .MemErr(MemErr)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; IReq = 1'b0; DReq = 1'b0; DWB = 1'b0; MemReady = 1'b0;
    IAddr = '0; DAddr = '0; DVictimAddr = '0; DVictimData = '0; MemRD = '0;
    step();
    step();
    RST_N = 1'b1;
    step();
  endtask

  // Transaction-level reference: which port owns memory, the accesses it still
  // owes, and the data each port must be showing.
  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
  } acc_t;

  acc_t        exp_q[$];
  logic        mdl_on = 1'b0;
  bit          mdl_prev = 1'b0;
  bit          m_free, m_owner_d, m_last_d, m_done_due;
  logic [31:0] m_ird, m_drd, m_last_rd;

  initial begin
    forever begin
      @(negedge CLK);
      if (mdl_on && !mdl_prev) begin
        m_free = 1'b1; m_last_d = 1'b1; m_done_due = 1'b0;
        m_ird = '0; m_drd = '0; m_last_rd = '0;
        exp_q.delete();
      end
      mdl_prev = mdl_on;
      if (mdl_on) begin
        automatic bit exp_i = m_done_due && !m_owner_d;
        automatic bit exp_d = m_done_due && m_owner_d;
        chk("idone", IDone, exp_i);
        chk("ddone", DDone, exp_d);
        chk("istall", IStall, IReq && !exp_i);
        chk("dstall", DStall, DReq && !exp_d);
        chk("busy", Busy, !m_free);
        if (m_free) begin
          chk("memen_idle", MemEn, 1'b0);
          if (IReq || DReq) begin
            automatic bit win_d = DReq && (!IReq || !RR || !m_last_d);
            if (win_d) begin
              if (DWB) exp_q.push_back('{a: DVictimAddr & 32'hFFFF_FFFC, we: 1'b1, wd: DVictimData});
              exp_q.push_back('{a: DAddr & 32'hFFFF_FFFC, we: 1'b0, wd: 32'h0});
            end else begin
              exp_q.push_back('{a: IAddr & 32'hFFFF_FFFC, we: 1'b0, wd: 32'h0});
            end
            m_last_d  = win_d;
            m_owner_d = win_d;
            m_free    = 1'b0;
          end
        end else if (m_done_due) begin
          if (m_owner_d) m_drd = m_last_rd;
          else           m_ird = m_last_rd;
          m_done_due = 1'b0;
          m_free     = 1'b1;
        end else if (MemReady) begin
          if (exp_q.size() == 0) begin
            chk("acc_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            automatic acc_t e = exp_q.pop_front();
            chk("acc_addr", MemA, e.a);
            chk("acc_we", MemWE, e.we);
            if (e.we) chk("acc_wd", MemWD, e.wd);
            else      m_last_rd = MemRD;
            if (exp_q.size() == 0) m_done_due = 1'b1;
          end
        end
        chk("ird_hold", IRD, m_ird);
        chk("drd_hold", DRD, m_drd);
        chk("memerr_clear", MemErr, 1'b0);
        if (MemEn) chk("mema_align", {30'd0, MemA[1:0]}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  logic [31:0] exp_order [4];
  bit          mem_busy, mem_hold, stop_new, i_seen, d_seen, got_i;
  int          mem_wait;

  initial begin
    if (RR) begin
      exp_order[0] = 32'h40; exp_order[1] = 32'h80; exp_order[2] = 32'h40; exp_order[3] = 32'h80;
    end else begin
      exp_order[0] = 32'h80; exp_order[1] = 32'h80; exp_order[2] = 32'h80; exp_order[3] = 32'h80;
    end

    // Reset values
    RST_N = 1'b0; IReq = 1'b0; DReq = 1'b0; DWB = 1'b0; MemReady = 1'b0;
    IAddr = '0; DAddr = '0; DVictimAddr = '0; DVictimData = '0; MemRD = '0;
    step();
    step();
    chk("rst_idone", IDone, 0); chk("rst_ddone", DDone, 0);
    chk("rst_ird", IRD, 0); chk("rst_drd", DRD, 0);
    chk("rst_memen", MemEn, 0); chk("rst_memwe", MemWE, 0);
    chk("rst_mema", MemA, 0); chk("rst_memwd", MemWD, 0);
    chk("rst_memerr", MemErr, 0); chk("rst_busy", Busy, 0);
    RST_N = 1'b1;
    step();

    // Clean D miss, memory answers on the second MemEn cycle
    DReq = 1'b1; DWB = 1'b0; DAddr = 32'h104;
    step();
    chk("clean_busy", Busy, 1); chk("clean_memen0", MemEn, 0);
    DAddr = 32'hFFFF_FFFF;
    step();
    chk("clean_memen", MemEn, 1); chk("clean_mema", MemA, 32'h104); chk("clean_memwe", MemWE, 0);
    step();
    chk("clean_nodone", DDone, 0);
    MemReady = 1'b1; MemRD = 32'hDEAD_BEEF;
    step();
    MemReady = 1'b0; MemRD = 32'h0;
    chk("clean_ddone", DDone, 1); chk("clean_drd", DRD, 32'hDEAD_BEEF);
    chk("clean_memen_resp", MemEn, 0); chk("clean_dstall", DStall, 0);
    step();
    DReq = 1'b0;
    chk("clean_pulse", DDone, 0); chk("clean_idle", Busy, 0); chk("clean_drd_hold", DRD, 32'hDEAD_BEEF);

    // Dirty D miss with 1-cycle memory: DDone lands in the fifth cycle after grant
    do_reset();
    DReq = 1'b1; DWB = 1'b1; DVictimAddr = 32'h203; DVictimData = 32'h1122_3344; DAddr = 32'h300;
    step();
    DWB = 1'b0; DVictimData = 32'h0;
    step();
    chk("dirty_wb_en", MemEn, 1); chk("dirty_wb_we", MemWE, 1);
    chk("dirty_wb_a", MemA, 32'h200); chk("dirty_wb_wd", MemWD, 32'h1122_3344);
    MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    chk("dirty_gap_en", MemEn, 1); chk("dirty_gap_a", MemA, 32'h200); chk("dirty_gap_done", DDone, 0);
    step();
    chk("dirty_rd_a", MemA, 32'h300); chk("dirty_rd_we", MemWE, 0); chk("dirty_rd_done", DDone, 0);
    MemReady = 1'b1; MemRD = 32'hCAFE_F00D;
    step();
    MemReady = 1'b0;
    chk("dirty_ddone", DDone, 1); chk("dirty_drd", DRD, 32'hCAFE_F00D);
    step();
    DReq = 1'b0;
    chk("dirty_pulse", DDone, 0);

    // Timeout: no MemReady ever
    do_reset();
    DReq = 1'b1; DWB = 1'b0; DAddr = 32'h500; MemRD = 32'h5A5A_5A5A;
    step();
    for (int i = 1; i < 15; i++) begin
      step();
      if (DDone || MemErr) chk("to_early", {30'd0, DDone, MemErr}, 32'd0);
    end
    chk("to_early_none", {30'd0, DDone, MemErr}, 32'd0);
    step();
    chk("to_ddone", DDone, 1); chk("to_err", MemErr, 1); chk("to_drd", DRD, 32'h5A5A_5A5A);
    step();
    DReq = 1'b0;
    chk("to_pulse", DDone, 0);
    step();
    step();
    chk("to_sticky", MemErr, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("to_err_reset", MemErr, 0);
    step();
    RST_N = 1'b1;
    step();

    // Async reset in the middle of a writeback, then an I refill
    do_reset();
    DReq = 1'b1; DWB = 1'b1; DVictimAddr = 32'h600; DVictimData = 32'h77; DAddr = 32'h700;
    step();
    step();
    chk("rwb_in_wb", MemWE, 1);
    #2;
    RST_N = 1'b0; DReq = 1'b0;
    #1;
    chk("rwb_memen", MemEn, 0); chk("rwb_memwe", MemWE, 0); chk("rwb_mema", MemA, 0);
    chk("rwb_memwd", MemWD, 0); chk("rwb_busy", Busy, 0); chk("rwb_ddone", DDone, 0);
    step();
    RST_N = 1'b1;
    step();
    chk("rwb_no_done", DDone, 0);
    IReq = 1'b1; IAddr = 32'h47;
    step();
    chk("rwb_i_busy", Busy, 1);
    step();
    chk("rwb_i_memen", MemEn, 1); chk("rwb_i_mema", MemA, 32'h44); chk("rwb_i_we", MemWE, 0);
    MemReady = 1'b1; MemRD = 32'h0BAD_F00D;
    step();
    MemReady = 1'b0;
    chk("rwb_idone", IDone, 1); chk("rwb_ird", IRD, 32'h0BAD_F00D); chk("rwb_i_dd", DDone, 0);
    step();
    IReq = 1'b0;
    chk("rwb_i_pulse", IDone, 0); chk("rwb_i_idle", Busy, 0);

    // Repeated ties with both requests held through every Done
    do_reset();
    IReq = 1'b1; IAddr = 32'h40; DReq = 1'b1; DAddr = 32'h80; DWB = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      automatic int n = 0;
      while (!MemEn && n < 20) begin
        step();
        n++;
      end
      chk("tie_memen", MemEn, 1);
      got_i = (MemA == 32'h40);
      chk("tie_order", MemA, exp_order[k]);
      MemReady = 1'b1; MemRD = 32'hA000 + 32'(k);
      step();
      MemReady = 1'b0;
      chk("tie_done", {30'd0, IDone, DDone}, got_i ? 32'd2 : 32'd1);
      if (!got_i) chk("tie_istall", IStall, 1);
      if (k == 3) begin
        IReq = 1'b0; DReq = 1'b0;
      end
      step();
      chk("tie_idle", Busy, 0);
      if (k < 3) begin
        step();
        chk("tie_regrant", Busy, 1);
      end
    end

    // Randomized traffic against the transaction-level reference
    do_reset();
    mem_busy = 1'b0; mem_hold = 1'b0; mem_wait = 0; stop_new = 1'b0;
    mdl_on = 1'b1;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge CLK);
      i_seen = IDone;
      d_seen = DDone;
      @(posedge CLK);
      #1;
      stop_new = (cyc >= 3000);
      if (stop_new && !IReq && !DReq && !Busy) break;
      MemReady = 1'b0;
      MemRD    = $urandom;
      if (mem_hold) begin
        mem_hold = 1'b0;
      end else if (MemEn) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = $urandom_range(0, 3);
        end
        if (mem_wait == 0) begin
          MemReady = 1'b1;
          mem_busy = 1'b0;
          mem_hold = 1'b1;
        end else begin
          mem_wait--;
        end
      end
      if (IReq) begin
        if (i_seen && (stop_new || $urandom_range(0, 1) == 0)) IReq = 1'b0;
      end else if (!stop_new && $urandom_range(0, 3) == 0) begin
        IReq = 1'b1;
      end
      if (DReq) begin
        if (d_seen && (stop_new || $urandom_range(0, 1) == 0)) DReq = 1'b0;
      end else if (!stop_new && $urandom_range(0, 3) == 0) begin
        DReq = 1'b1;
      end
      IAddr       = $urandom;
      DAddr       = $urandom;
      DWB         = 1'($urandom_range(0, 1));
      DVictimAddr = $urandom;
      DVictimData = $urandom;
    end
    chk("rand_drained", {30'd0, IReq || DReq, Busy}, 32'd0);
    step();
    mdl_on = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache writeback/refill path.
- A central FSM grants one requester at a time and sequences the memory transactions:
  - D-cache miss: optional dirty-victim writeback, then line refill.
  - I-cache miss: refill only.
- Returns refill data and a one-cycle completion pulse to the granted cache.
- Sits between the cache blocks and data memory, and generates the pipeline stall signals.

Parameters:
- DATA_WIDTH, 32, width of addresses and data words.
- MEM_TIMEOUT, 15, max cycles to wait for MemReady in one memory phase before flagging an error.
- CNT_WIDTH, 4, width of the phase cycle counter; must satisfy 2**CNT_WIDTH > MEM_TIMEOUT.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IReq  in  1  I-cache refill request; held high until IDone.
- IAddr  in  DATA_WIDTH  I-cache miss address.
- DReq  in  1  D-cache miss request; held high until DDone.
- DWB  in  1  victim is dirty; writeback required before refill.
- DAddr  in  DATA_WIDTH  D-cache miss (refill) address.
- DVictimAddr  in  DATA_WIDTH  dirty victim address.
- DVictimData  in  DATA_WIDTH  dirty victim data.
- MemRD  in  DATA_WIDTH  memory read data; valid when MemReady=1.
- MemReady  in  1  one-cycle pulse: current memory access complete.
- IDone  out  1  one-cycle pulse: I refill complete; IRD valid.
- IRD  out  DATA_WIDTH  registered I refill data.
- DDone  out  1  one-cycle pulse: D transaction complete; DRD valid.
- DRD  out  DATA_WIDTH  registered D refill data.
- MemEn  out  1  memory access active.
- MemWE  out  1  memory write (1) or read (0).
- MemA  out  DATA_WIDTH  memory address; bits [1:0] always 0.
- MemWD  out  DATA_WIDTH  memory write data.
- IStall  out  1  IReq & ~IDone.
- DStall  out  1  DReq & ~DDone.
- Busy  out  1  FSM not in IDLE.
- MemErr  out  1  sticky: a memory phase timed out.

Behaviour:
- Reset (RST_N=0, async):
  - State=IDLE.
  - All registered outputs 0: IDone, DDone, IRD, DRD, MemEn, MemWE, MemA, MemWD, MemErr.
  - Counter, latched addresses and victim data are cleared.
- Reset mid-transaction: abort with no Done pulse. Requesters re-issue after reset.
- States: IDLE, I_FILL, D_WB, D_FILL, I_RESP, D_RESP.
- IDLE: IReq/DReq sampled only in this state.
  - Grant priority: D over I (see Optional Feature).
  - On grant, latch the address (and DWB, DVictimAddr, DVictimData for D) with bits [1:0] zeroed.
  - Requester inputs may change afterwards without effect.
- IDLE transitions:
  - D grant with DWB=1 -> D_WB.
  - D grant with DWB=0 -> D_FILL.
  - I grant -> I_FILL.
  - No request -> stay in IDLE.
- D_WB:
  - Drives MemEn=1, MemWE=1, MemA=victim addr, MemWD=victim data.
  - On MemReady -> D_FILL.
  - MemEn stays high across the transition; the new address appears the next cycle.
- D_FILL / I_FILL:
  - Drives MemEn=1, MemWE=0, MemA=latched miss addr.
  - On MemReady, capture MemRD into DRD / IRD, then go to D_RESP / I_RESP.
- I_RESP / D_RESP:
  - Exactly one cycle; MemEn=0.
  - Pulses IDone / DDone, then returns to IDLE.
  - The requester must drop Req on the edge ending the Done cycle; a Req still high in the following IDLE is treated as a new miss.
- Output latency: MemEn, MemA, MemWE and MemWD are registered and valid the cycle after state entry.
  - Min D latency without writeback: grant edge -> DDone = 3 cycles with 1-cycle memory.
  - Min D latency with writeback: 5 cycles.
- MemReady handling: ignored in IDLE and RESP states.
  - MemReady in the same cycle as state entry counts (memory may answer combinationally).
- IRD/DRD hold their value until the next capture for that port.
- Timeout:
  - The counter resets on every phase entry and increments each cycle without MemReady.
  - Reaching MEM_TIMEOUT sets MemErr (sticky until reset) and forces the RESP state.
  - Done pulses, and IRD/DRD capture the current MemRD.
- Simultaneous IReq & DReq in IDLE: only one is granted. The loser stays stalled and is granted on a later IDLE visit.
- Stall outputs are combinational from Req and Done.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined:
  - A last-grant flop (reset value = D) selects the winner when both requests are present in IDLE: the port not last served wins.
  - The flop updates on each grant.
  - A lone request is granted immediately.
- Undefined:
  - Fixed priority, D always wins ties.
  - No last-grant flop exists.

Test Plan:
- Clean D miss: DReq=1, DWB=0, DAddr=0x104, MemReady after 2 cycles, MemRD=0xDEADBEEF -> MemA=0x104, MemWE=0; DDone one cycle; DRD=0xDEADBEEF; Busy low after.
- Dirty D miss: DWB=1, DVictimAddr=0x203, DVictimData=0x11223344, DAddr=0x300 -> write to MemA=0x200 with WD=0x11223344, then read at 0x300; single DDone at end.
- Simultaneous IReq (0x40) & DReq (0x80):
  - Without the macro: D served first, then I.
  - With the macro, repeated ties: grants alternate I, D, I, D.
- Timeout: DReq with MemReady never asserted -> MemErr=1 after 15 cycles in the phase; DDone pulses; MemErr stays 1 until RST_N low.
- Async reset while in D_WB -> all outputs 0 immediately, state IDLE, no DDone; a subsequent IReq is served normally.
- Back-to-back: DReq reasserted the cycle after DDone -> new grant with no idle gap beyond one IDLE cycle; IStall held throughout if IReq is pending (fixed priority).
